// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit acting as initiator on the data port of the
// unified ram. One byte/half/word request at a time over valid/ready,
// loads are sign- or zero-extended, sub-word stores are read-modify-write
// of the containing word because ram only writes whole words.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses
// with resp_error; when undefined the low address bits are aligned down.
module mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [DATA_WIDTH-1:0] d_read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                state;
    logic [1:0]            size_q;
    logic [1:0]            lane_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic       req_word;
    logic       req_half;
    logic [1:0] req_lane;
    logic       misaligned;
    logic       addr_unused;

    // Size 11 behaves as a word access.
    assign req_word = req_size[1];
    assign req_half = (req_size == 2'b01);

    // Lane with the bits below the access size forced to zero.
    assign req_lane = req_word ? 2'b00 :
                      req_half ? {req_addr[1], 1'b0} : req_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (req_half && req_addr[0]) ||
                        (req_word && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Address bits above the ram size are ignored, so accesses wrap.
    assign addr_unused = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == IDLE) && !reset;

    // Pick the addressed lane out of a ram word and extend it to 32 bits.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic [1:0]            lane,
        input logic                  zext
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        if (size[1])
            return word;
        else if (size[0])
            return {{16{h[15] & ~zext}}, h};
        else
            return {{24{b[7] & ~zext}}, b};
    endfunction

    // Replace the addressed lane of the old ram word with the store data.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            size,
        input logic [1:0]            lane
    );
        logic [DATA_WIDTH-1:0] m;
        m = old;
        if (size[1])
            m = wdata;
        else if (size[0])
            m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        else
            m[{lane, 3'b000} +: 8] = wdata[7:0];
        return m;
    endfunction

    // Request sequencer: latch on handshake, walk RD/WR/RESP, drive every output from a register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            wEn          <= 1'b0;
            d_address    <= '0;
            d_write_data <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle with non-blocking
            // assignments; the case below only raises them for one cycle.
            resp_valid <= 1'b0;
            wEn        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q     <= req_size;
                        lane_q     <= req_lane;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            d_address <= req_addr[ADDR_WIDTH+1:2];
                            if (req_write && req_word) begin
                                state        <= WR;
                                wEn          <= 1'b1;
                                d_write_data <= req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        state        <= WR;
                        wEn          <= 1'b1;
                        d_write_data <= store_merge(d_read_data, wdata_q, size_q, lane_q);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_extend(d_read_data, size_q, lane_q, unsigned_q);
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state     <= IDLE;
                    d_address <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
